sobel_window_gen: RTL and testbench
===================================

Name: sobel_window_gen

Overview:
- Front end of the Sobel pipeline. Accepts a raster pixel stream at PIXEL pixels per beat and buffers two previous rows in on-chip line buffers.
- Emits, per output beat, PIXEL overlapping 3x3 windows packed as three row buses. These buses drive the partial-sum adder stage.
- Acts as the strobe/busy transmitter to that stage: o_strobe is valid, i_busy is downstream backpressure.

Parameters:
- PIXEL, 3, pixels per beat; must be >= 2.
- ROW_LOOP, 3, window width in columns; fixed at 3.
- DATAWIDTH, 8, bits per pixel.
- LINE_BEATS, 4, beats per image row; must be >= 2.

Ports:
- clk  input  1  clock.
- ARESET  input  1  synchronous, active-high reset.
- in_data  input  DATAWIDTH*PIXEL  input beat; pixel p at [DATAWIDTH*p +: DATAWIDTH], p=0 is leftmost.
- in_strobe  input  1  input beat valid.
- in_tlast  input  1  last beat of frame.
- o_busy  output  1  backpressure to upstream.
- packed_out_0  output  DATAWIDTH*PIXEL*ROW_LOOP  top window row (oldest).
- packed_out_1  output  DATAWIDTH*PIXEL*ROW_LOOP  middle window row.
- packed_out_2  output  DATAWIDTH*PIXEL*ROW_LOOP  bottom window row (current).
- o_strobe  output  1  output beat valid.
- i_busy  input  1  downstream backpressure.
- out_tlast  output  1  last output beat of frame.
- o_err  output  1  sticky framing error.

Behaviour:
- Packing: packed_out_r[DATAWIDTH*(ROW_LOOP*i+j) +: DATAWIDTH] = pixel at row (R-2+r), column (PIXEL*k + i + j).
  - k is the output beat column index; R is the current row; j=0 is the leftmost window column.
- Valid-only convolution: windows never use padding.
- Input accept: in_strobe && !o_busy. Output transfer: o_strobe && !i_busy.
- Counters:
  - col_cnt counts 0..LINE_BEATS-1 and wraps; row_cnt increments on each wrap.
  - row_cnt saturates at 2 for the window-valid decision.
- Line buffers: two RAMs of LINE_BEATS words x DATAWIDTH*PIXEL bits.
  - On accept at column c, read lb1[c] and lb0[c].
  - Write lb0[c] <= lb1[c] and lb1[c] <= in_data.
- Previous-beat registers hold the last accepted beat for all three rows.
- Window for beat k is formed on acceptance of beat k+1 of the same row.
  - It uses all PIXEL pixels of beat k plus pixels 0..1 of beat k+1.
  - Accepting column 0 produces no output.
  - Each row from row 2 onward yields LINE_BEATS-1 output beats; rows 0 and 1 yield none.
- Latency: output registered 1 cycle after the enabling accept.
- Output stage: output register plus one skid register.
  - o_busy = skid register full (registered).
  - Skid fills when a new window is produced while the output register is held by i_busy.
  - Skid drains into the output register on the next transfer.
  - Data is never lost or duplicated under any i_busy pattern.
- out_tlast is asserted with the window produced by the accept carrying in_tlast, i.e. the last output beat of the frame.
- On in_tlast accept, col_cnt and row_cnt clear to 0 for the next frame. Line buffer contents are don't-care, since rows 0 and 1 are never output.
- Simultaneous input accept and output transfer in the same cycle are supported at full throughput (1 beat/cycle) when i_busy = 0.
- Reset values:
  - o_strobe=0, out_tlast=0, o_err=0.
  - o_busy=1 during reset, deasserting the cycle after reset release.
  - packed_out_* = 0, counters = 0, skid empty.
- Reset mid-frame discards all buffered and pending beats.

Optional Feature:
- Macro: SOBEL_WIN_TLAST_CHECK_EN.
- Defined: in_tlast accepted with col_cnt != LINE_BEATS-1 sets o_err, which is sticky until ARESET.
  - No out_tlast window is emitted for the bad beat; counters clear (resync).
  - A frame ending with col_cnt = LINE_BEATS-1 but no in_tlast is not checked.
- Undefined: o_err is tied to 0.
  - in_tlast clears the counters regardless of position.
  - out_tlast is still asserted on the window produced by that accept, if any.

Test Plan:
- Setup for all cases: PIXEL=3, LINE_BEATS=4, pixel value = row*16+col.
- Basic window: send a 4-row frame, i_busy=0 -> first o_strobe 1 cycle after accepting input beat 9.
  - packed_out_0 pixel0 = {02,01,00}, packed_out_2 pixel0 = {22,21,20}.
  - Pixel2 bottom = {24,23,22}.
  - 6 output beats total; out_tlast only on the 6th.
- Throughput: continuous in_strobe, i_busy=0 -> o_busy never asserts after reset; output beats arrive back-to-back within each row.
- Backpressure: hold i_busy=1 for 5 cycles mid-row -> o_busy asserts once the skid fills.
  - After release, the output sequence is identical to the no-stall run (no loss or duplication).
- Frame restart: two frames back-to-back -> frame 2's first output appears after its beat 9.
  - Frame 2 windows contain no frame 1 pixels.
- Framing error (macro on): in_tlast on col 2 of row 2 -> o_err=1 and stays 1.
  - Next well-formed frame produces 6 correct beats.
  - Macro off: o_err stays 0.
- Reset mid-frame: assert ARESET during row 2 -> o_strobe=0 and o_busy=1 in reset.
  - A fresh frame afterwards produces correct windows.

Source files
------------

// File: rtl/sobel_window_gen_if.sv
// Stream bundle between the raster source, the Sobel window generator and the
// partial-sum adder stage. The slave view is the window generator itself.
interface sobel_window_gen_if #(
    parameter int PIXEL     = 3,
    parameter int ROW_LOOP  = 3,
    parameter int DATAWIDTH = 8
);
    logic [DATAWIDTH*PIXEL-1:0]          in_data;
    logic                                in_strobe;
    logic                                in_tlast;
    logic                                o_busy;
    logic [DATAWIDTH*PIXEL*ROW_LOOP-1:0] packed_out_0;
    logic [DATAWIDTH*PIXEL*ROW_LOOP-1:0] packed_out_1;
    logic [DATAWIDTH*PIXEL*ROW_LOOP-1:0] packed_out_2;
    logic                                o_strobe;
    logic                                i_busy;
    logic                                out_tlast;

    modport master (
        output in_data, in_strobe, in_tlast, i_busy,
        input  o_busy, packed_out_0, packed_out_1, packed_out_2, o_strobe, out_tlast
    );

    modport slave (
        input  in_data, in_strobe, in_tlast, i_busy,
        output o_busy, packed_out_0, packed_out_1, packed_out_2, o_strobe, out_tlast
    );
endinterface

// File: rtl/sobel_window_gen.sv
// Sobel front end: two line buffers plus previous-beat registers form PIXEL 3x3 windows per beat.
// Define SOBEL_WIN_TLAST_CHECK_EN to flag in_tlast arriving before the last beat of a row (sticky o_err).
module sobel_window_gen #(
    parameter int PIXEL      = 3,
    parameter int ROW_LOOP   = 3,
    parameter int DATAWIDTH  = 8,
    parameter int LINE_BEATS = 4
) (
    input  logic              clk,
    input  logic              ARESET,
    sobel_window_gen_if.slave stream,
    output logic              o_err
);
    localparam int BEAT_W = DATAWIDTH * PIXEL;
    localparam int ROW_W  = BEAT_W * ROW_LOOP;
    localparam int CNT_W  = (LINE_BEATS > 2) ? $clog2(LINE_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(LINE_BEATS - 1);

    typedef enum logic [1:0] {
        OUT_EMPTY,
        OUT_ONE,
        OUT_FULL
    } out_state_t;

    generate
        if (PIXEL < 2 || ROW_LOOP != 3 || LINE_BEATS < 2) begin : g_param_check
            $error("sobel_window_gen: PIXEL>=2, ROW_LOOP==3 and LINE_BEATS>=2 are required");
        end
    endgenerate

    logic                   o_busy_reg;
    logic                   accept;
    logic [CNT_W-1:0]       col_cnt_reg;
    logic [CNT_W-1:0]       col_cnt_next;
    logic [1:0]             row_cnt_reg;
    logic [1:0]             row_cnt_next;
    logic                   bad_tlast;
    logic                   win_valid;
    logic                   win_tlast;

    logic [BEAT_W-1:0]      lb0_mem [LINE_BEATS];
    logic [BEAT_W-1:0]      lb1_mem [LINE_BEATS];
    logic [BEAT_W-1:0]      lb0_rd_reg;
    logic [BEAT_W-1:0]      lb1_rd_reg;

    logic [2:0][BEAT_W-1:0] cur_beat;
    logic [2:0][BEAT_W-1:0] prev_reg;
    logic [2:0][ROW_W-1:0]  win_row;

    out_state_t             out_state_reg;
    out_state_t             out_state_next;
    logic                   load_out_win;
    logic                   load_out_skid;
    logic                   load_skid;
    logic [2:0][ROW_W-1:0]  out_row_reg;
    logic                   out_tlast_reg;
    logic [2:0][ROW_W-1:0]  skid_row_reg;
    logic                   skid_tlast_reg;

    assign accept = stream.in_strobe && !o_busy_reg;

    // Column/row position; in_tlast always resynchronises to the top of a new frame.
    always_comb begin
        col_cnt_next = col_cnt_reg;
        row_cnt_next = row_cnt_reg;
        if (accept) begin
            if (stream.in_tlast) begin
                col_cnt_next = '0;
                row_cnt_next = 2'd0;
            end else if (col_cnt_reg == LAST_COL) begin
                col_cnt_next = '0;
                if (row_cnt_reg != 2'd2) begin
                    row_cnt_next = row_cnt_reg + 2'd1;
                end
            end else begin
                col_cnt_next = col_cnt_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ARESET) begin
            col_cnt_reg <= '0;
            row_cnt_reg <= 2'd0;
        end else begin
            col_cnt_reg <= col_cnt_next;
            row_cnt_reg <= row_cnt_next;
        end
    end

    // Line buffers are read one beat ahead (address = next column) so the
    // registered read data is already waiting when that column is accepted.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0_mem[col_cnt_reg] <= lb1_rd_reg;
            lb1_mem[col_cnt_reg] <= stream.in_data;
        end
        lb0_rd_reg <= lb0_mem[col_cnt_next];
        lb1_rd_reg <= lb1_mem[col_cnt_next];
    end

    assign cur_beat[0] = lb0_rd_reg;
    assign cur_beat[1] = lb1_rd_reg;
    assign cur_beat[2] = stream.in_data;

    always_ff @(posedge clk) begin
        if (ARESET) begin
            prev_reg <= '0;
        end else if (accept) begin
            prev_reg <= cur_beat;
        end
    end

    // Window i spans pixels i..i+ROW_LOOP-1 of the previous beat extended by the current beat.
    generate
        for (genvar gr = 0; gr < 3; gr++) begin : g_row
            for (genvar gi = 0; gi < PIXEL; gi++) begin : g_win
                for (genvar gj = 0; gj < ROW_LOOP; gj++) begin : g_tap
                    if (gi + gj < PIXEL) begin : g_prev
                        assign win_row[gr][DATAWIDTH*(ROW_LOOP*gi+gj) +: DATAWIDTH] =
                            prev_reg[gr][DATAWIDTH*(gi+gj) +: DATAWIDTH];
                    end else begin : g_cur
                        assign win_row[gr][DATAWIDTH*(ROW_LOOP*gi+gj) +: DATAWIDTH] =
                            cur_beat[gr][DATAWIDTH*(gi+gj-PIXEL) +: DATAWIDTH];
                    end
                end
            end
        end
    endgenerate

`ifdef SOBEL_WIN_TLAST_CHECK_EN
    logic err_reg;

    assign bad_tlast = accept && stream.in_tlast && (col_cnt_reg != LAST_COL);

    always_ff @(posedge clk) begin
        if (ARESET) begin
            err_reg <= 1'b0;
        end else if (bad_tlast) begin
            err_reg <= 1'b1;
        end
    end

    assign o_err = err_reg;
`else
    assign bad_tlast = 1'b0;
    assign o_err     = 1'b0;
`endif

    assign win_valid = accept && (col_cnt_reg != '0) && (row_cnt_reg == 2'd2) && !bad_tlast;
    assign win_tlast = stream.in_tlast;

    // Output register plus skid: a new window is never offered while the skid is full.
    always_comb begin
        out_state_next = out_state_reg;
        load_out_win   = 1'b0;
        load_out_skid  = 1'b0;
        load_skid      = 1'b0;
        case (out_state_reg)
            OUT_EMPTY: begin
                if (win_valid) begin
                    load_out_win   = 1'b1;
                    out_state_next = OUT_ONE;
                end
            end
            OUT_ONE: begin
                if (win_valid) begin
                    if (!stream.i_busy) begin
                        load_out_win = 1'b1;
                    end else begin
                        load_skid      = 1'b1;
                        out_state_next = OUT_FULL;
                    end
                end else if (!stream.i_busy) begin
                    out_state_next = OUT_EMPTY;
                end
            end
            OUT_FULL: begin
                if (!stream.i_busy) begin
                    load_out_skid  = 1'b1;
                    out_state_next = OUT_ONE;
                end
            end
            default: begin
                out_state_next = OUT_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (ARESET) begin
            out_state_reg  <= OUT_EMPTY;
            o_busy_reg     <= 1'b1;
            out_row_reg    <= '0;
            out_tlast_reg  <= 1'b0;
            skid_row_reg   <= '0;
            skid_tlast_reg <= 1'b0;
        end else begin
            out_state_reg <= out_state_next;
            o_busy_reg    <= (out_state_next == OUT_FULL);
            if (load_out_win) begin
                out_row_reg   <= win_row;
                out_tlast_reg <= win_tlast;
            end else if (load_out_skid) begin
                out_row_reg   <= skid_row_reg;
                out_tlast_reg <= skid_tlast_reg;
            end else if (out_state_next == OUT_EMPTY) begin
                out_tlast_reg <= 1'b0;
            end
            if (load_skid) begin
                skid_row_reg   <= win_row;
                skid_tlast_reg <= win_tlast;
            end
        end
    end

    assign stream.o_busy       = o_busy_reg;
    assign stream.o_strobe     = (out_state_reg != OUT_EMPTY);
    assign stream.out_tlast    = out_tlast_reg;
    assign stream.packed_out_0 = out_row_reg[0];
    assign stream.packed_out_1 = out_row_reg[1];
    assign stream.packed_out_2 = out_row_reg[2];
endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen: a frame-image reference model predicts every window.
module tb_sobel_window_gen;
    localparam int PIXEL      = 3;
    localparam int ROW_LOOP   = 3;
    localparam int DATAWIDTH  = 8;
    localparam int LINE_BEATS = 4;
    localparam int NCOL       = PIXEL * LINE_BEATS;
    localparam int BW         = DATAWIDTH * PIXEL;
    localparam int RW         = BW * ROW_LOOP;

    typedef struct packed {
        logic [RW-1:0] r0;
        logic [RW-1:0] r1;
        logic [RW-1:0] r2;
        logic          tlast;
    } exp_t;

    logic clk = 1'b0;
    logic ARESET;
    logic o_err;

    always #5 clk = ~clk;

    sobel_window_gen_if #(.PIXEL(PIXEL), .ROW_LOOP(ROW_LOOP), .DATAWIDTH(DATAWIDTH)) bus ();

    sobel_window_gen #(
        .PIXEL(PIXEL), .ROW_LOOP(ROW_LOOP), .DATAWIDTH(DATAWIDTH), .LINE_BEATS(LINE_BEATS)
    ) dut (
        .clk(clk),
        .ARESET(ARESET),
        .stream(bus),
        .o_err(o_err)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    exp_t exp_q[$];
    logic [DATAWIDTH-1:0] img [0:7][0:NCOL-1];
    bit   busy_force = 1'b0;
    int   busy_pct   = 0;
    bit   busy_seen  = 1'b0;
    int   out_count  = 0;
    int   tlast_count = 0;
    bit   last_tlast = 1'b0;
    int   out_cyc [0:63];
    int   acc9_cyc = -1;
    logic [RW-1:0] first_r0;
    logic [RW-1:0] first_r2;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_bus(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: the 3x3 windows taken straight from the stored frame image.
    function automatic exp_t model_window(input int r, input int c, input logic t);
        exp_t e;
        logic [RW-1:0] rows [3];
        for (int rr = 0; rr < 3; rr++) begin
            rows[rr] = '0;
            for (int i = 0; i < PIXEL; i++)
                for (int j = 0; j < ROW_LOOP; j++)
                    rows[rr][DATAWIDTH*(ROW_LOOP*i+j) +: DATAWIDTH] = img[r-2+rr][PIXEL*(c-1)+i+j];
        end
        e.r0 = rows[0];
        e.r1 = rows[1];
        e.r2 = rows[2];
        e.tlast = t;
        return e;
    endfunction

    initial begin
        bus.i_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.i_busy = busy_force || ($urandom_range(99) < busy_pct);
        end
    end

    task automatic drive_beat(input logic [BW-1:0] d, input logic t, input int r, input int c);
        int waitc;
        bit emit;
        bus.in_data   = d;
        bus.in_strobe = 1'b1;
        bus.in_tlast  = t;
        waitc = 0;
        @(negedge clk);
        while (bus.o_busy && waitc < 500) begin
            @(negedge clk);
            waitc++;
        end
        check_int("accept_wait", int'(bus.o_busy), 0);
        if (!bus.o_busy) begin
            if (r == 2 && c == 1) acc9_cyc = cyc;
`ifdef SOBEL_WIN_TLAST_CHECK_EN
            emit = !(t && (c != LINE_BEATS - 1));
`else
            emit = 1'b1;
`endif
            if (r >= 2 && c >= 1 && emit) exp_q.push_back(model_window(r, c, t));
        end
        @(posedge clk);
        #1;
        bus.in_strobe = 1'b0;
        bus.in_tlast  = 1'b0;
    endtask

    task automatic send_frame(input bit rnd, input int end_row, input int end_col,
                              input bit end_tlast, input int gap_pct);
        for (int r = 0; r <= end_row; r++) begin
            for (int c = 0; c < LINE_BEATS; c++) begin
                logic [BW-1:0] d;
                if (r == end_row && c > end_col) break;
                for (int p = 0; p < PIXEL; p++) begin
                    img[r][PIXEL*c+p] = rnd ? DATAWIDTH'($urandom) : DATAWIDTH'(r*16 + PIXEL*c + p);
                    d[DATAWIDTH*p +: DATAWIDTH] = img[r][PIXEL*c+p];
                end
                if ($urandom_range(99) < gap_pct) begin
                    @(posedge clk);
                    #1;
                end
                drive_beat(d, (r == end_row && c == end_col) ? end_tlast : 1'b0, r, c);
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check_int("drain", exp_q.size(), 0);
    endtask

    task automatic clear_stats();
        out_count   = 0;
        tlast_count = 0;
        last_tlast  = 1'b0;
        busy_seen   = 1'b0;
    endtask

    // Monitor: every downstream transfer must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!ARESET) begin
                if (bus.o_busy) busy_seen = 1'b1;
                if (bus.o_strobe && !bus.i_busy) begin
                    check_int("expected_pending", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check_bus("row0", bus.packed_out_0, e.r0);
                        check_bus("row1", bus.packed_out_1, e.r1);
                        check_bus("row2", bus.packed_out_2, e.r2);
                        check_int("out_tlast", int'(bus.out_tlast), int'(e.tlast));
                    end
                    if (out_count == 0) begin
                        first_r0 = bus.packed_out_0;
                        first_r2 = bus.packed_out_2;
                    end
                    if (out_count < 64) out_cyc[out_count] = cyc;
                    out_count++;
                    if (bus.out_tlast) tlast_count++;
                    last_tlast = bus.out_tlast;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int exp_err;
`ifdef SOBEL_WIN_TLAST_CHECK_EN
        exp_err = 1;
`else
        exp_err = 0;
`endif
        ARESET        = 1'b1;
        bus.in_data   = '0;
        bus.in_strobe = 1'b0;
        bus.in_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_int("rst_strobe", int'(bus.o_strobe), 0);
        check_int("rst_busy", int'(bus.o_busy), 1);
        check_int("rst_tlast", int'(bus.out_tlast), 0);
        check_int("rst_err", int'(o_err), 0);
        check_bus("rst_packed0", bus.packed_out_0, '0);
        @(posedge clk);
        #1;
        ARESET = 1'b0;
        @(posedge clk);
        #1;
        check_int("busy_after_release", int'(bus.o_busy), 0);

        // Basic ramp frame at full rate
        clear_stats();
        t0 = cyc;
        send_frame(1'b0, 3, LINE_BEATS - 1, 1'b1, 0);
        check_int("frame_cycles", cyc - t0, 16);
        drain();
        check_int("basic_count", out_count, 6);
        check_int("basic_tlasts", tlast_count, 1);
        check_int("basic_last_is_tlast", int'(last_tlast), 1);
        check_int("first_latency", out_cyc[0], acc9_cyc + 1);
        check_int("back_to_back", out_cyc[1], out_cyc[0] + 1);
        check_int("top_px0", int'(first_r0[23:0]), 32'h020100);
        check_int("bot_px0", int'(first_r2[23:0]), 32'h222120);
        check_int("bot_px2", int'(first_r2[71:48]), 32'h242322);
        check_int("no_busy_full_rate", int'(busy_seen), 0);

        // Five-cycle downstream stall during row 3
        clear_stats();
        fork
            send_frame(1'b0, 3, LINE_BEATS - 1, 1'b1, 0);
            begin
                repeat (13) @(posedge clk);
                #1;
                busy_force = 1'b1;
                repeat (5) @(posedge clk);
                #1;
                busy_force = 1'b0;
            end
        join
        drain();
        check_int("stall_busy_seen", int'(busy_seen), 1);
        check_int("stall_count", out_count, 6);
        check_int("stall_tlasts", tlast_count, 1);

        // Back-to-back frames, second one random
        clear_stats();
        send_frame(1'b0, 3, LINE_BEATS - 1, 1'b1, 0);
        send_frame(1'b1, 3, LINE_BEATS - 1, 1'b1, 0);
        drain();
        check_int("restart_count", out_count, 12);
        check_int("restart_latency", out_cyc[6], acc9_cyc + 1);

        // Random frames with random gaps and backpressure
        clear_stats();
        busy_pct = 30;
        for (int f = 0; f < 3; f++)
            send_frame(1'b1, $urandom_range(6, 2), LINE_BEATS - 1, 1'b1, 25);
        busy_pct = 0;
        drain();
        check_int("random_tlasts", tlast_count, 3);

        // Early tlast in row 2, then a clean frame
        clear_stats();
        send_frame(1'b0, 2, 2, 1'b1, 0);
        drain();
        check_int("err_after_bad", int'(o_err), exp_err);
        clear_stats();
        send_frame(1'b1, 3, LINE_BEATS - 1, 1'b1, 0);
        drain();
        check_int("resync_count", out_count, 6);
        check_int("err_sticky", int'(o_err), exp_err);

        // Reset in the middle of row 2 with windows pending
        busy_force = 1'b1;
        send_frame(1'b1, 2, 2, 1'b0, 0);
        ARESET = 1'b1;
        exp_q.delete();
        busy_force = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_int("midrst_strobe", int'(bus.o_strobe), 0);
        check_int("midrst_busy", int'(bus.o_busy), 1);
        check_int("midrst_err", int'(o_err), 0);
        @(posedge clk);
        #1;
        ARESET = 1'b0;
        @(posedge clk);
        #1;
        clear_stats();
        send_frame(1'b1, 3, LINE_BEATS - 1, 1'b1, 0);
        drain();
        check_int("post_rst_count", out_count, 6);
        check_int("post_rst_tlasts", tlast_count, 1);

        check_int("leftover", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
